// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: tile-pass sequencer for the weight-stationary systolic array.
// One pass: stream col kernel words (kernel-load op), one settle cycle, stream
// len activation vectors (execute op), wait out the array drain, pulse done.
// Per-row instruction lanes are a shift chain so row r sees the op r cycles
// after row 0, matching the diagonal wavefront of data through the array.
//
// Handshake: start is a request sampled only while IDLE (busy=0); it is
// accepted on that edge and cfg_len is captured with it. Requests while busy
// (including the DONE cycle) are dropped. done is a single-cycle completion
// pulse; the next start may be accepted in the cycle after done.
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 10,
    parameter int addr_bw = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [len_bw-1:0]    cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd,
    output logic [addr_bw-1:0]   mem_addr,
    output logic [2*row-1:0]     inst_row,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Phase lengths in counter width; one extra bit keeps row+col and any
    // cfg_len representable without overflow.
    localparam logic [len_bw:0]    kload_last = (len_bw + 1)'(col);
    localparam logic [len_bw:0]    drain_last = (len_bw + 1)'(row + col);
    localparam logic [addr_bw-1:0] exec_base  = addr_bw'(col);

    state_t              state, next_state;
    logic [len_bw:0]     cnt, cnt_n, cnt_inc;
    logic [len_bw-1:0]   len_q, len_n;
    logic                rd_n;
    logic [addr_bw-1:0]  addr_n;
    logic [1:0]          issued_op;
    logic [2*row-1:0]    inst_q;

    assign cnt_inc   = cnt + 1'b1;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign inst_row  = inst_q;
    assign state_dbg = state;

    // State, phase counter, latched length and registered SRAM controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_n;
            len_q    <= len_n;
            mem_rd   <= rd_n;
            mem_addr <= addr_n;
        end
    end

    // Next-state, phase counting, and next SRAM read request/address.
    always_comb begin
        next_state = state;
        cnt_n      = cnt;
        len_n      = len_q;
        rd_n       = 1'b0;
        addr_n     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = KLOAD;
                    cnt_n      = '0;
                    len_n      = cfg_len;
                end
            end
            KLOAD: begin
                if (cnt_inc == kload_last) begin
                    next_state = GAP;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            GAP: begin
                next_state = (len_q == '0) ? DRAIN : EXEC;
                cnt_n      = '0;
            end
            EXEC: begin
                if (cnt_inc == {1'b0, len_q}) begin
                    next_state = DRAIN;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DRAIN: begin
                if (cnt_inc == drain_last) begin
                    next_state = DONE;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                cnt_n      = '0;
            end
        endcase

        // Reads run continuously through a phase; the first read of a phase
        // loads its base address, later reads step by one (wrapping silently).
        rd_n = (next_state == KLOAD) || (next_state == EXEC);
        if (rd_n) begin
            if (next_state == state)
                addr_n = mem_addr + 1'b1;
            else if (next_state == KLOAD)
                addr_n = '0;
            else
                addr_n = exec_base;
        end
    end

    // Op issued this cycle, decoded from the current phase.
    always_comb begin
        issued_op = 2'b00;
        if (state == KLOAD)
            issued_op = 2'b01;
        else if (state == EXEC)
            issued_op = 2'b11;
    end

    // Lane 0 delays the op one cycle to line up with SRAM read data; each
    // further lane adds one more cycle of skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q <= '0;
        end else begin
            inst_q[1:0] <= issued_op;
            for (int r = 1; r < row; r++) begin
                inst_q[2*r +: 2] <= inst_q[2*(r-1) +: 2];
            end
        end
    end

endmodule
